permutation_ctrl: RTL and testbench

PERMUTATION_CTRL -- requirements
Module: permutation_ctrl

---
 rtl/permutation_ctrl_if.sv | 32 +++
 rtl/permutation_ctrl.sv | 107 ++++++++++
 tb/tb_permutation_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/permutation_ctrl_if.sv
// Control bus between the permutation round controller and its user.
// The user (master) launches permutations; the controller (slave) drives
// the round index and the datapath steering/enable signals.
interface permutation_ctrl_if;
    logic       start_i;
    logic       mode_i;
    logic [3:0] round_o;
    logic       data_sel_o;
    logic       en_reg_state_o;
    logic       busy_o;
    logic       done_o;

    modport master (
        output start_i,
        output mode_i,
        input  round_o,
        input  data_sel_o,
        input  en_reg_state_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  mode_i,
        output round_o,
        output data_sel_o,
        output en_reg_state_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/permutation_ctrl.sv
// Round controller for an iterated permutation (p^a / p^b).
// Sequences the round index and steers the state register: the first
// enabled cycle loads the external state, later cycles feed back the
// registered state, and a one-cycle done pulse marks the final value.
// All outputs are registered and are a pure function of state and cnt.
module permutation_ctrl #(
    parameter int unsigned NB_ROUNDS_A = 12,
    parameter int unsigned NB_ROUNDS_B = 6
) (
    input logic               clock_i,
    input logic               resetb_i,
    permutation_ctrl_if.slave bus
);

    localparam logic [3:0] LastRound  = 4'(NB_ROUNDS_A - 1);
    localparam logic [3:0] FirstRndB  = 4'(NB_ROUNDS_A - NB_ROUNDS_B);

    typedef enum logic [1:0] {StIdle, StFirst, StRound, StDone} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] round;
    logic       data_sel;
    logic       en_reg_state;
    logic       busy;
    logic       done;

    // FSM, round counter and registered Moore outputs; each branch sets
    // the outputs belonging to the state being entered.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state        <= StIdle;
            cnt          <= 4'd0;
            round        <= 4'd0;
            data_sel     <= 1'b0;
            en_reg_state <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start_i) begin
                        state        <= StFirst;
                        cnt          <= bus.mode_i ? FirstRndB : 4'd0;
                        round        <= bus.mode_i ? FirstRndB : 4'd0;
                        data_sel     <= 1'b0;
                        en_reg_state <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                StFirst: begin
                    state        <= StRound;
                    cnt          <= cnt + 4'd1;
                    round        <= cnt + 4'd1;
                    data_sel     <= 1'b1;
                    en_reg_state <= 1'b1;
                    busy         <= 1'b1;
                    done         <= 1'b0;
                end
                StRound: begin
                    if (cnt == LastRound) begin
                        // Counter holds at the last round so round_o stays valid during done.
                        state        <= StDone;
                        en_reg_state <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        cnt          <= cnt + 4'd1;
                        round        <= cnt + 4'd1;
                        en_reg_state <= 1'b1;
                        done         <= 1'b0;
                    end
                    data_sel <= 1'b1;
                    busy     <= 1'b1;
                end
                StDone: begin
                    state        <= StIdle;
                    cnt          <= 4'd0;
                    round        <= 4'd0;
                    data_sel     <= 1'b0;
                    en_reg_state <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
                default: begin
                    state        <= StIdle;
                    cnt          <= 4'd0;
                    round        <= 4'd0;
                    data_sel     <= 1'b0;
                    en_reg_state <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

    // Drive the bus straight from the output registers.
    always_comb begin
        bus.round_o        = round;
        bus.data_sel_o     = data_sel;
        bus.en_reg_state_o = en_reg_state;
        bus.busy_o         = busy;
        bus.done_o         = done;
    end

endmodule

// File: tb/tb_permutation_ctrl.sv
// Testbench for permutation_ctrl: table-driven permutation runs through an
// ASCON round datapath, hand-written back-to-back and reset sequences, and
// a randomized phase compared against a cycle-count reference model.
module tb_permutation_ctrl;
    localparam int A = 12;
    localparam int B = 6;

    logic clock_i = 1'b0;
    logic resetb_i = 1'b0;

    permutation_ctrl_if bus ();

    permutation_ctrl #(
        .NB_ROUNDS_A(A),
        .NB_ROUNDS_B(B)
    ) dut (
        .clock_i (clock_i),
        .resetb_i(resetb_i),
        .bus     (bus)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int failures = 0;

    logic [7:0] dut_out;
    assign dut_out = {bus.round_o, bus.data_sel_o, bus.en_reg_state_o, bus.busy_o, bus.done_o};

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- ASCON round function and datapath ----------------
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, ~r, r};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] ascon_perm(input logic [319:0] s, input int first);
        logic [319:0] v;
        v = s;
        for (int r = first; r < A; r++) v = ascon_round(v, 4'(r));
        return v;
    endfunction

    logic [319:0] ext_state;
    logic [319:0] state_reg;

    always @(posedge clock_i) begin
        if (bus.en_reg_state_o)
            state_reg <= ascon_round(bus.data_sel_o ? state_reg : ext_state, bus.round_o);
    end

    // ---------------- Reference model ----------------
    // An accepted start opens a run of n enabled cycles starting at round
    // base, followed by one done cycle; k counts cycles into the run.
    bit m_active = 1'b0;
    int m_k = 0;
    int m_base = 0;
    int m_n = 0;

    function automatic logic [7:0] model_out();
        int rnd;
        if (!m_active) return 8'h00;
        rnd = (m_k < m_n) ? m_base + m_k : m_base + m_n - 1;
        return {4'(rnd), (m_k != 0), (m_k < m_n), 1'b1, (m_k == m_n)};
    endfunction

    task automatic model_step(input logic s, input logic m);
        if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_k      = 0;
                m_base   = m ? A - B : 0;
                m_n      = m ? B : A;
            end
        end else if (m_k == m_n) begin
            m_active = 1'b0;
        end else begin
            m_k++;
        end
    endtask

    // ---------------- One permutation, observed cycle by cycle ----------------
    task automatic run_vec(input logic mode, input bit poke, input bit toggle,
                           output int first_rnd, output bit first_sel, output int en_cnt,
                           output int sel0_cnt, output int done_cnt, output int done_edge,
                           output int done_rnd, output logic [319:0] done_state,
                           output bit timeout);
        bit seen_en;
        seen_en = 1'b0;
        first_rnd = -1; first_sel = 1'b1; en_cnt = 0; sel0_cnt = 0; done_cnt = 0;
        done_edge = -1; done_rnd = -1; done_state = '0; timeout = 1'b1;
        @(negedge clock_i);
        bus.start_i = 1'b1;
        bus.mode_i  = mode;
        @(posedge clock_i);
        #1;
        bus.start_i = 1'b0;
        if (toggle) bus.mode_i = ~mode;
        for (int e = 0; e < 40; e++) begin
            @(negedge clock_i);
            bus.start_i = 1'b0;
            if (bus.en_reg_state_o) begin
                if (!seen_en) begin
                    seen_en   = 1'b1;
                    first_rnd = int'(bus.round_o);
                    first_sel = bus.data_sel_o;
                end
                en_cnt++;
                if (!bus.data_sel_o) sel0_cnt++;
                if (poke && bus.round_o == 4'd5) bus.start_i = 1'b1;
            end
            if (bus.done_o) begin
                done_cnt++;
                done_edge  = e;
                done_rnd   = int'(bus.round_o);
                done_state = state_reg;
            end
            if (!bus.busy_o) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    typedef struct {
        logic mode;
        bit   poke;
        bit   toggle;
        int   exp_first;
        int   exp_en;
        int   exp_done_edge;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int first_rnd, en_cnt, sel0_cnt, done_cnt, done_edge, done_rnd;
        bit first_sel, timeout, found;
        logic [319:0] done_state;
        logic [7:0] exp8;

        vecs[0] = '{mode: 1'b0, poke: 1'b0, toggle: 1'b0, exp_first: 0, exp_en: 12, exp_done_edge: 12};
        vecs[1] = '{mode: 1'b1, poke: 1'b0, toggle: 1'b0, exp_first: 6, exp_en: 6,  exp_done_edge: 6};
        vecs[2] = '{mode: 1'b0, poke: 1'b1, toggle: 1'b0, exp_first: 0, exp_en: 12, exp_done_edge: 12};
        vecs[3] = '{mode: 1'b1, poke: 1'b0, toggle: 1'b1, exp_first: 6, exp_en: 6,  exp_done_edge: 6};
        vecs[4] = '{mode: 1'b0, poke: 1'b0, toggle: 1'b1, exp_first: 0, exp_en: 12, exp_done_edge: 12};

        ext_state = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaaff,
                     64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};
        state_reg = '0;

        // Reset held with start high and the clock running.
        bus.start_i = 1'b1;
        bus.mode_i  = 1'b0;
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        check("reset_state", dut_out, 8'h00);
        bus.start_i = 1'b0;
        resetb_i = 1'b1;

        // Table-driven permutation runs.
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i].mode, vecs[i].poke, vecs[i].toggle, first_rnd, first_sel, en_cnt,
                    sel0_cnt, done_cnt, done_edge, done_rnd, done_state, timeout);
            check($sformatf("v%0d_timeout", i), timeout, 1'b0);
            check($sformatf("v%0d_first_round", i), first_rnd, vecs[i].exp_first);
            check($sformatf("v%0d_first_sel", i), first_sel, 1'b0);
            check($sformatf("v%0d_en_cycles", i), en_cnt, vecs[i].exp_en);
            check($sformatf("v%0d_sel0_cycles", i), sel0_cnt, 1);
            check($sformatf("v%0d_done_pulses", i), done_cnt, 1);
            check($sformatf("v%0d_done_edge", i), done_edge, vecs[i].exp_done_edge);
            check($sformatf("v%0d_done_round", i), done_rnd, A - 1);
            check($sformatf("v%0d_result", i), done_state, ascon_perm(ext_state, vecs[i].exp_first));
        end

        // Back-to-back p^b with start held: 6 enabled, 1 done, 1 idle, repeating.
        @(negedge clock_i);
        bus.start_i = 1'b1;
        bus.mode_i  = 1'b1;
        @(posedge clock_i);
        for (int j = 0; j < 24; j++) begin
            int p;
            @(negedge clock_i);
            p = j % 8;
            if (p < 6)       exp8 = {4'(6 + p), (p != 0), 1'b1, 1'b1, 1'b0};
            else if (p == 6) exp8 = {4'd11, 1'b1, 1'b0, 1'b1, 1'b1};
            else             exp8 = 8'h00;
            check($sformatf("b2b_cycle%0d", j), dut_out, exp8);
        end
        bus.start_i = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock_i);
            if (!bus.busy_o) begin
                found = 1'b1;
                break;
            end
        end
        check("b2b_drain", found, 1'b1);

        // Reset asserted at round 4 of p^a aborts at once.
        @(negedge clock_i);
        bus.start_i = 1'b1;
        bus.mode_i  = 1'b0;
        @(posedge clock_i);
        #1 bus.start_i = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock_i);
            if (bus.en_reg_state_o && bus.round_o == 4'd4) begin
                found = 1'b1;
                break;
            end
        end
        check("midrst_reach_round4", found, 1'b1);
        resetb_i = 1'b0;
        #1;
        check("midrst_immediate", dut_out, 8'h00);
        @(posedge clock_i);
        #1;
        check("midrst_held", dut_out, 8'h00);
        @(negedge clock_i);
        resetb_i = 1'b1;
        run_vec(1'b0, 1'b0, 1'b0, first_rnd, first_sel, en_cnt, sel0_cnt, done_cnt, done_edge,
                done_rnd, done_state, timeout);
        check("midrst_rerun_timeout", timeout, 1'b0);
        check("midrst_rerun_first", first_rnd, 0);
        check("midrst_rerun_en", en_cnt, 12);
        check("midrst_rerun_done_edge", done_edge, 12);
        check("midrst_rerun_result", done_state, ascon_perm(ext_state, 0));

        // Randomized phase against the reference model, synced by a reset.
        @(negedge clock_i);
        resetb_i = 1'b0;
        m_active = 1'b0;
        bus.start_i = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock_i);
            check($sformatf("rand_c%0d", c), dut_out, model_out());
            if (!resetb_i) begin
                resetb_i = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                resetb_i = 1'b0;
                m_active = 1'b0;
                #1;
                check($sformatf("rand_rst_c%0d", c), dut_out, model_out());
            end
            bus.start_i = ($urandom_range(0, 3) == 0);
            bus.mode_i  = 1'($urandom_range(0, 1));
            @(posedge clock_i);
            if (resetb_i) model_step(bus.start_i, bus.mode_i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
